// File: rtl/alu_exec_unit.sv
// RV32I execute unit: ALU-op decoder plus 32-bit ALU.
// Out/ALUop are combinational; Out_q/ALUop_q are their 1-cycle registered copies.
module alu_exec_unit #(
  parameter int WIDTH = 32
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct,
  input  logic             add_rshift_type,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [3:0]       ALUop,
  output logic [WIDTH-1:0] Out,
  output logic [3:0]       ALUop_q,
  output logic [WIDTH-1:0] Out_q
);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SLL  = 4'd5;
  localparam logic [3:0] OP_SRL  = 4'd6;
  localparam logic [3:0] OP_SRA  = 4'd7;
  localparam logic [3:0] OP_SLT  = 4'd8;
  localparam logic [3:0] OP_SLTU = 4'd9;
  localparam logic [3:0] OP_CPB  = 4'd10;
  localparam logic [3:0] OP_XXX  = 4'd15;

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_I      = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;

  logic       is_r;
  logic [3:0] arith_op;
  logic [4:0] shamt;
  logic       slt;
  logic       sltu;

  assign is_r  = (opcode == OPC_R);
  assign shamt = B[4:0];
  assign slt   = $signed(A) < $signed(B);
  assign sltu  = A < B;

  // Shared R/I arithmetic decode; only R-type may turn ADD into SUB.
  always_comb begin
    arith_op = OP_XXX;
    case (funct)
      3'b000: arith_op = (is_r && add_rshift_type) ? OP_SUB : OP_ADD;
      3'b001: arith_op = OP_SLL;
      3'b010: arith_op = OP_SLT;
      3'b011: arith_op = OP_SLTU;
      3'b100: arith_op = OP_XOR;
      3'b101: arith_op = add_rshift_type ? OP_SRA : OP_SRL;
      3'b110: arith_op = OP_OR;
      3'b111: arith_op = OP_AND;
      default: arith_op = OP_XXX;
    endcase
  end

  always_comb begin
    ALUop = OP_XXX;
    case (opcode)
      OPC_R, OPC_I: ALUop = arith_op;
      OPC_LUI:      ALUop = OP_CPB;
      OPC_AUIPC, OPC_JAL, OPC_JALR,
      OPC_BRANCH, OPC_LOAD, OPC_STORE:
        ALUop = OP_ADD;
      default:      ALUop = OP_XXX;
    endcase
  end

  always_comb begin
    Out = '0;
    case (ALUop)
      OP_ADD:  Out = A + B;
      OP_SUB:  Out = A - B;
      OP_AND:  Out = A & B;
      OP_OR:   Out = A | B;
      OP_XOR:  Out = A ^ B;
      OP_SLL:  Out = A << shamt;
      OP_SRL:  Out = A >> shamt;
      OP_SRA:  Out = $unsigned($signed(A) >>> shamt);
      OP_SLT:  Out = {{(WIDTH-1){1'b0}}, slt};
      OP_SLTU: Out = {{(WIDTH-1){1'b0}}, sltu};
      OP_CPB:  Out = B;
      default: Out = '0;
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      Out_q   <= '0;
      ALUop_q <= '0;
    end else begin
      Out_q   <= Out;
      ALUop_q <= ALUop;
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed corners, random
// stimulus against a behavioural model, registered path and reset.
module tb_alu_exec_unit;

  logic        Clock;
  logic        Reset;
  logic [6:0]  opcode;
  logic [2:0]  funct;
  logic        add_rshift_type;
  logic [31:0] A;
  logic [31:0] B;
  logic [3:0]  ALUop;
  logic [31:0] Out;
  logic [3:0]  ALUop_q;
  logic [31:0] Out_q;

  int errors = 0;
  int checks = 0;

  logic [3:0]  exp_op;
  logic [31:0] exp_out;

  alu_exec_unit #(.WIDTH(32)) dut (
    .Clock(Clock),
    .Reset(Reset),
    .opcode(opcode),
    .funct(funct),
    .add_rshift_type(add_rshift_type),
    .A(A),
    .B(B),
    .ALUop(ALUop),
    .Out(Out),
    .ALUop_q(ALUop_q),
    .Out_q(Out_q)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: opcode class -> operation, then plain arithmetic.
  function automatic void model(input logic [6:0] opc,
                                input logic [2:0] f3,
                                input logic t,
                                input logic [31:0] a,
                                input logic [31:0] b,
                                output logic [3:0] op,
                                output logic [31:0] res);
    int unsigned sh;
    int sa;
    int sb;
    sh = int'(b) & 31;
    sa = a;
    sb = b;
    if (opc == 7'h33 || opc == 7'h13) begin
      case (f3)
        3'd0: op = (opc == 7'h33 && t) ? 4'd1 : 4'd0;
        3'd1: op = 4'd5;
        3'd2: op = 4'd8;
        3'd3: op = 4'd9;
        3'd4: op = 4'd4;
        3'd5: op = t ? 4'd7 : 4'd6;
        3'd6: op = 4'd3;
        default: op = 4'd2;
      endcase
    end else if (opc == 7'h37) begin
      op = 4'd10;
    end else if (opc == 7'h17 || opc == 7'h6F ||
                 opc == 7'h67 || opc == 7'h63 ||
                 opc == 7'h03 || opc == 7'h23) begin
      op = 4'd0;
    end else begin
      op = 4'd15;
    end
    case (op)
      4'd0: res = a + b;
      4'd1: res = a - b;
      4'd2: res = a & b;
      4'd3: res = a | b;
      4'd4: res = a ^ b;
      4'd5: res = a << sh;
      4'd6: res = a >> sh;
      4'd7: begin
        res = a >> sh;
        if (a[31] && sh != 0)
          res = res | ~(32'hFFFF_FFFF >> sh);
      end
      4'd8: res = (sa < sb) ? 32'd1 : 32'd0;
      4'd9: res = (a < b) ? 32'd1 : 32'd0;
      4'd10: res = b;
      default: res = 32'd0;
    endcase
  endfunction

  task automatic drive(input logic [6:0] opc,
                       input logic [2:0] f3,
                       input logic t,
                       input logic [31:0] a,
                       input logic [31:0] b);
    @(negedge Clock);
    opcode = opc;
    funct = f3;
    add_rshift_type = t;
    A = a;
    B = b;
    #1;
    model(opc, f3, t, a, b, exp_op, exp_out);
  endtask

  task automatic check_comb(input string tag);
    chk({tag, "_op"}, {28'd0, ALUop}, {28'd0, exp_op});
    chk({tag, "_out"}, Out, exp_out);
  endtask

  task automatic check_reg(input string tag);
    @(posedge Clock);
    #1;
    chk({tag, "_opq"}, {28'd0, ALUop_q}, {28'd0, exp_op});
    chk({tag, "_outq"}, Out_q, exp_out);
  endtask

  initial begin
    Reset = 1'b1;
    opcode = 7'h33;
    funct = 3'd0;
    add_rshift_type = 1'b0;
    A = 32'd9;
    B = 32'd4;
    repeat (2) @(posedge Clock);
    #1;
    chk("rst_outq", Out_q, 32'd0);
    chk("rst_opq", {28'd0, ALUop_q}, 32'd0);
    chk("rst_comb_out", Out, 32'd13);
    @(negedge Clock);
    Reset = 1'b0;

    drive(7'h33, 3'd0, 1'b0, 32'h7FFF_FFFF, 32'd1);
    chk("add_ovf", Out, 32'h8000_0000);
    chk("add_op", {28'd0, ALUop}, 32'd0);
    drive(7'h33, 3'd0, 1'b1, 32'd0, 32'd1);
    chk("sub_0_1", Out, 32'hFFFF_FFFF);
    chk("sub_op", {28'd0, ALUop}, 32'd1);
    drive(7'h13, 3'd5, 1'b1, 32'h8000_0000, 32'h1F);
    chk("srai_31", Out, 32'hFFFF_FFFF);
    drive(7'h13, 3'd5, 1'b0, 32'h8000_0000, 32'h1F);
    chk("srli_31", Out, 32'h0000_0001);
    drive(7'h13, 3'd5, 1'b1, 32'h8000_0000, 32'h20);
    chk("sra_sh0", Out, 32'h8000_0000);
    drive(7'h33, 3'd1, 1'b0, 32'h1234_5678, 32'hFFFF_FFE0);
    chk("sll_sh0", Out, 32'h1234_5678);
    drive(7'h33, 3'd2, 1'b0, 32'h8000_0000, 32'd0);
    chk("slt_neg", Out, 32'd1);
    drive(7'h33, 3'd3, 1'b0, 32'h8000_0000, 32'd0);
    chk("sltu_big", Out, 32'd0);
    drive(7'h13, 3'd0, 1'b1, 32'd5, 32'd3);
    chk("addi_t1", Out, 32'd8);
    drive(7'h37, 3'd0, 1'b0, 32'h1234, 32'hABCD_E000);
    chk("lui", Out, 32'hABCD_E000);
    chk("lui_op", {28'd0, ALUop}, 32'd10);
    drive(7'h23, 3'd2, 1'b0, 32'h100, 32'h4);
    chk("store", Out, 32'h104);
    drive(7'h7F, 3'd0, 1'b0, 32'h55, 32'h66);
    chk("bad_op", {28'd0, ALUop}, 32'd15);
    chk("bad_out", Out, 32'd0);
    drive(7'h33, 3'd7, 1'b0, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
    chk("and", Out, 32'h00F0_00F0);
    drive(7'h33, 3'd6, 1'b0, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
    chk("or", Out, 32'hFFF0_FFF0);
    drive(7'h33, 3'd4, 1'b0, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
    chk("xor", Out, 32'hFF00_FF00);

    drive(7'h33, 3'd0, 1'b0, 32'd2, 32'd3);
    @(posedge Clock);
    #1;
    chk("reg_add_outq", Out_q, 32'd5);
    chk("reg_add_opq", {28'd0, ALUop_q}, 32'd0);
    #2;
    Reset = 1'b1;
    #1;
    chk("midrst_outq", Out_q, 32'd0);
    chk("midrst_comb", Out, 32'd5);
    @(posedge Clock);
    #1;
    chk("rst_hold_outq", Out_q, 32'd0);
    drive(7'h33, 3'd0, 1'b1, 32'd20, 32'd7);
    Reset = 1'b0;
    chk("rel_outq_pre", Out_q, 32'd0);
    @(posedge Clock);
    #1;
    chk("rel_outq", Out_q, 32'd13);
    chk("rel_opq", {28'd0, ALUop_q}, 32'd1);

    for (int i = 0; i < 300; i++) begin
      logic [6:0] opc;
      logic [31:0] rb;
      case ($urandom_range(0, 9))
        0, 1, 2: opc = 7'h33;
        3, 4, 5: opc = 7'h13;
        6: opc = 7'h37;
        7: opc = 7'h23;
        8: opc = 7'h63;
        default: opc = 7'($urandom);
      endcase
      rb = $urandom;
      if ($urandom_range(0, 3) == 0)
        rb = rb & 32'h8000_003F;
      drive(opc, 3'($urandom), 1'($urandom),
            $urandom, rb);
      check_comb("rnd");
      check_reg("rnd");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
